// File: rtl/perf_counter_bank.sv
// Bank of saturating event counters plus a BCD elapsed-time counter, gated by a START_PC..FINAL_PC window.
// Optional macro PERF_SNAPSHOT_EN adds shadow registers captured by snap and used as the readout source.
module perf_counter_bank #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned TIME_DIGITS    = 5,
    parameter int unsigned TICKS_PER_UNIT = 500_000,
    parameter logic [15:0] START_PC       = 16'h0000,
    parameter logic [15:0] FINAL_PC       = 16'h0000
) (
    input  logic                                  cpu_clk,
    input  logic                                  resetN,
    input  logic [15:0]                           pc,
    input  logic                                  clear,
    input  logic [NUM_CHANNELS-1:0]               event_in,
    input  logic                                  snap,
    input  logic [$clog2(NUM_CHANNELS+1)-1:0]     rd_sel,
    input  logic [3:0]                            rd_digit,
    output logic                                  running,
    output logic                                  finished,
    output logic [NUM_CHANNELS-1:0]               overflow,
    output logic [3:0]                            rd_nibble
);

    localparam int unsigned SEL_W   = $clog2(NUM_CHANNELS + 1);
    localparam int unsigned PRE_W   = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int unsigned NIBBLES = COUNTER_WIDTH / 4;
    localparam int unsigned TD_RD   = (TIME_DIGITS < 16) ? TIME_DIGITS : 16;
    localparam int unsigned CN_RD   = (NIBBLES < 16) ? NIBBLES : 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    logic [COUNTER_WIDTH-1:0]   cnt     [NUM_CHANNELS];
    logic [PRE_W-1:0]           presc;
    logic [3:0]                 bcd     [TIME_DIGITS];
    logic [3:0]                 bcd_inc [TIME_DIGITS];
    logic                       bcd_all9;
    logic                       carry;
    logic [COUNTER_WIDTH-1:0]   src_cnt [NUM_CHANNELS];
    logic [3:0]                 src_bcd [TIME_DIGITS];
    logic [3:0]                 nib_sel;

    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            running  <= 1'b0;
            finished <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            running  <= 1'b0;
            finished <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pc == START_PC) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: if (pc == FINAL_PC) begin
                    state    <= DONE;
                    running  <= 1'b0;
                    finished <= 1'b1;
                end
                DONE: ;
                default: begin
                    state    <= IDLE;
                    running  <= 1'b0;
                    finished <= 1'b0;
                end
            endcase
        end
    end

    // A counter already at all-ones that sees another event holds and flags saturation.
    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN) begin
            cnt      <= '{default: '0};
            overflow <= '0;
        end else if (clear) begin
            cnt      <= '{default: '0};
            overflow <= '0;
        end else if (state == RUN) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (event_in[c]) begin
                    if (cnt[c] == '1) overflow[c] <= 1'b1;
                    else              cnt[c]      <= cnt[c] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        bcd_inc  = bcd;
        bcd_all9 = 1'b1;
        carry    = 1'b1;
        for (int unsigned d = 0; d < TIME_DIGITS; d++) begin
            if (bcd[d] != 4'd9) bcd_all9 = 1'b0;
        end
        for (int unsigned d = 0; d < TIME_DIGITS; d++) begin
            if (carry) begin
                if (bcd[d] == 4'd9) begin
                    bcd_inc[d] = 4'd0;
                end else begin
                    bcd_inc[d] = bcd[d] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN) begin
            presc <= '0;
            bcd   <= '{default: '0};
        end else if (clear) begin
            presc <= '0;
            bcd   <= '{default: '0};
        end else if (state == RUN) begin
            if (presc == PRE_W'(TICKS_PER_UNIT - 1)) begin
                presc <= '0;
                if (!bcd_all9) bcd <= bcd_inc;
            end else begin
                presc <= presc + PRE_W'(1);
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [COUNTER_WIDTH-1:0] cnt_sh [NUM_CHANNELS];
    logic [3:0]               bcd_sh [TIME_DIGITS];

    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN) begin
            cnt_sh <= '{default: '0};
            bcd_sh <= '{default: '0};
        end else if (clear) begin
            cnt_sh <= '{default: '0};
            bcd_sh <= '{default: '0};
        end else if (snap) begin
            cnt_sh <= cnt;
            bcd_sh <= bcd;
        end
    end

    always_comb begin
        src_cnt = cnt_sh;
        src_bcd = bcd_sh;
    end
`else
    logic unused_snap;
    assign unused_snap = snap;

    always_comb begin
        src_cnt = cnt;
        src_bcd = bcd;
    end
`endif

    // Out-of-range selections fall through to the zero default.
    always_comb begin
        nib_sel = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            for (int unsigned d = 0; d < CN_RD; d++) begin
                if (rd_sel == SEL_W'(c) && rd_digit == 4'(d)) nib_sel = src_cnt[c][4*d +: 4];
            end
        end
        for (int unsigned d = 0; d < TD_RD; d++) begin
            if (rd_sel == SEL_W'(NUM_CHANNELS) && rd_digit == 4'(d)) nib_sel = src_bcd[d];
        end
    end

    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN)    rd_nibble <= '0;
        else if (clear) rd_nibble <= '0;
        else            rd_nibble <= nib_sel;
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (2 channels, 8-bit counters, 2 BCD digits).
module tb_perf_counter_bank;

    logic        cpu_clk = 1'b0;
    logic        resetN;
    logic [15:0] pc;
    logic        clear;
    logic [1:0]  event_in;
    logic        snap;
    logic [1:0]  rd_sel;
    logic [3:0]  rd_digit;
    logic        running;
    logic        finished;
    logic [1:0]  overflow;
    logic [3:0]  rd_nibble;

    int n_checks = 0;
    int n_errors = 0;

    perf_counter_bank #(
        .NUM_CHANNELS  (2),
        .COUNTER_WIDTH (8),
        .TIME_DIGITS   (2),
        .TICKS_PER_UNIT(4),
        .START_PC      (16'h0010),
        .FINAL_PC      (16'h0040)
    ) dut (
        .cpu_clk  (cpu_clk),
        .resetN   (resetN),
        .pc       (pc),
        .clear    (clear),
        .event_in (event_in),
        .snap     (snap),
        .rd_sel   (rd_sel),
        .rd_digit (rd_digit),
        .running  (running),
        .finished (finished),
        .overflow (overflow),
        .rd_nibble(rd_nibble)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic read_nib(input logic [1:0] sel, input logic [3:0] dig, output logic [3:0] val);
        rd_sel   = sel;
        rd_digit = dig;
        tick(1);
        val = rd_nibble;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    logic [3:0] v;

    initial begin
        resetN = 1'b0; pc = 16'h0000; clear = 1'b0; event_in = 2'b01;
        snap = 1'b0; rd_sel = '0; rd_digit = '0;
        tick(2);
        check("reset_running", running, 0);
        check("reset_finished", finished, 0);
        check("reset_overflow", overflow, 0);
        check("reset_nibble", rd_nibble, 0);
        resetN = 1'b1;
        tick(1);

        // Window of 11 counted cycles: START cycle excluded, FINAL cycle included
        pc = 16'h0010; tick(1);
        check("start_running", running, 1);
        pc = 16'h0020; tick(10);
        pc = 16'h0040; tick(1);
        pc = 16'h0000;
        check("final_finished", finished, 1);
        check("final_running", running, 0);
        read_nib(2'd0, 4'd0, v); check("ch0_d0_B", v, 4'hB);
        read_nib(2'd0, 4'd1, v); check("ch0_d1_0", v, 4'h0);
        read_nib(2'd2, 4'd0, v); check("time_d0_2", v, 4'd2);

        pc = 16'h0010; tick(1);
        check("done_ignores_start", finished, 1);
        check("done_not_running", running, 0);
        pc = 16'h0000;

        pulse_clear();
        check("clear_running", running, 0);
        check("clear_finished", finished, 0);
        check("clear_overflow", overflow, 0);
        read_nib(2'd0, 4'd0, v); check("clear_ch0", v, 0);
        read_nib(2'd2, 4'd0, v); check("clear_time", v, 0);
        pc = 16'h0010; tick(1);
        check("restart_running", running, 1);

        // 40 counted cycles, ch1 enabled for the first 5
        pc = 16'h0020; event_in = 2'b11; tick(5);
        event_in = 2'b01; tick(34);
        pc = 16'h0040; tick(1);
        pc = 16'h0000;
        read_nib(2'd0, 4'd0, v); check("ch0_40_d0", v, 4'h8);
        read_nib(2'd0, 4'd1, v); check("ch0_40_d1", v, 4'h2);
        read_nib(2'd1, 4'd0, v); check("ch1_5", v, 4'h5);
        read_nib(2'd2, 4'd0, v); check("time10_d0", v, 4'd0);
        read_nib(2'd2, 4'd1, v); check("time10_d1", v, 4'd1);

        // 400 counted cycles: ch0 saturates, time holds at 99
        pulse_clear();
        pc = 16'h0010; tick(1);
        pc = 16'h0020; tick(399);
        check("sat_overflow", overflow, 2'b01);
        pc = 16'h0040; tick(1);
        pc = 16'h0000;
        check("sat_finished", finished, 1);
        read_nib(2'd0, 4'd0, v); check("sat_ch0_d0", v, 4'hF);
        read_nib(2'd0, 4'd1, v); check("sat_ch0_d1", v, 4'hF);
        read_nib(2'd1, 4'd0, v); check("sat_ch1", v, 4'h0);
        read_nib(2'd2, 4'd0, v); check("time99_d0", v, 4'd9);
        read_nib(2'd2, 4'd1, v); check("time99_d1", v, 4'd9);

        // Out-of-range reads and one-cycle latency
        rd_digit = 4'd5; #1;
        check("latency_hold", rd_nibble, 4'd9);
        tick(1);
        check("time_digit5", rd_nibble, 4'd0);
        read_nib(2'd3, 4'd0, v); check("sel3", v, 4'd0);
        read_nib(2'd0, 4'd2, v); check("ch0_digit2", v, 4'd0);

        // Snapshot at ch0=5, live value reaches 15
        pulse_clear();
        pc = 16'h0010; tick(1);
        pc = 16'h0020; tick(5);
        snap = 1'b1; tick(1);
        snap = 1'b0; tick(8);
        pc = 16'h0040; tick(1);
        pc = 16'h0000;
`ifdef PERF_SNAPSHOT_EN
        read_nib(2'd0, 4'd0, v); check("snap_ch0", v, 4'h5);
        read_nib(2'd2, 4'd0, v); check("snap_time", v, 4'd1);
`else
        read_nib(2'd0, 4'd0, v); check("live_ch0", v, 4'hF);
        read_nib(2'd2, 4'd0, v); check("live_time", v, 4'd3);
`endif
        read_nib(2'd0, 4'd1, v); check("snap_ch0_d1", v, 4'h0);
        clear = 1'b1; snap = 1'b1; tick(1);
        clear = 1'b0; snap = 1'b0;
        check("clear_snap_finished", finished, 0);
        read_nib(2'd0, 4'd0, v); check("clear_beats_snap", v, 0);

        // Asynchronous reset in the middle of a run
        pc = 16'h0010; tick(1);
        pc = 16'h0020; tick(3);
        rd_sel = 2'd0; rd_digit = 4'd0; tick(1);
        check("pre_reset_nibble", rd_nibble, 4'd3);
        check("pre_reset_running", running, 1);
        #2 resetN = 1'b0;
        #1;
        check("async_running", running, 0);
        check("async_nibble", rd_nibble, 0);
        tick(1);
        resetN = 1'b1;
        pc = 16'h0000;
        read_nib(2'd0, 4'd0, v); check("async_ch0", v, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
